console_adc_sched: RTL and testbench

- Upstream command/scheduling stage for the console USB/ADC handshake controller.
- Decodes host commands and issues one configuration request, then periodic or single conversion requests, using the fs_adc_conf/fd_adc_conf and fs_adc_conv/fd_adc_conv handshakes.
- Latches per-channel link status from adc_info after configuration.
- Counts completed conversions and dropped (overrun) sample ticks.

---
 rtl/console_adc_sched.sv | 235 +++++++++++++++++++++++
 tb/tb_console_adc_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/console_adc_sched.sv
// console_adc_sched: host command decoder that schedules ADC configuration and conversion fs/fd handshakes.
// Optional watchdog on stalled handshakes is enabled by defining SCHED_TIMEOUT_EN.
module console_adc_sched #(
  parameter int unsigned PRESCALE = 100,
  parameter int unsigned TIMEOUT  = 65535,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             com_valid,
  input  logic [15:0]      com_cmd,
  output logic             com_ready,
  output logic             fs_adc_conf,
  input  logic             fd_adc_conf,
  output logic             fs_adc_conv,
  input  logic             fd_adc_conv,
  input  logic [95:0]      adc_info,
  output logic             run,
  output logic             conf_ok,
  output logic [7:0]       link_mask,
  output logic [CNT_W-1:0] conv_cnt,
  output logic [7:0]       ovr_cnt,
  output logic [1:0]       err
);
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [3:0] OP_CONF   = 4'd1;
  localparam logic [3:0] OP_START  = 4'd2;
  localparam logic [3:0] OP_STOP   = 4'd3;
  localparam logic [3:0] OP_SINGLE = 4'd4;

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [2:0] {IDLE, CONF_REQ, CONF_REL, RUN_WAIT, CONV_REQ, CONV_REL, ERR_WAIT} state_t;
`else
  typedef enum logic [2:0] {IDLE, CONF_REQ, CONF_REL, RUN_WAIT, CONV_REQ, CONV_REL} state_t;
`endif

  state_t           state_q, state_d;
  logic             run_q, run_d;
  logic             conf_ok_q, conf_ok_d;
  logic [7:0]       link_mask_q, link_mask_d;
  logic [CNT_W-1:0] conv_cnt_q, conv_cnt_d;
  logic [7:0]       ovr_cnt_q, ovr_cnt_d;
  logic [1:0]       err_q, err_d;
  logic [11:0]      rate_q, rate_d;
  logic [11:0]      rcnt_q, rcnt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             com_ready_q, com_ready_d;
  logic             fs_conf_q, fs_conf_d;
  logic             fs_conv_q, fs_conv_d;
`ifdef SCHED_TIMEOUT_EN
  logic [TW-1:0]    wdog_q, wdog_d;
`endif

  logic       accept;
  logic       bad_op;
  logic       restart;
  logic       tick;
  logic       pre_wrap;
  logic [3:0] opcode;
  logic [7:0] mask_new;
  logic       unused_ok;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign opcode   = com_cmd[15:12];
  assign accept   = com_valid && com_ready_q;
  assign bad_op   = !(opcode inside {OP_CONF, OP_START, OP_STOP, OP_SINGLE});
  assign pre_wrap = (pre_q == PW'(PRESCALE - 1));
  assign tick     = run_q && pre_wrap && (rcnt_q == rate_q);

  // Two type bits per channel; channel 0 sits in the top pair and maps to mask bit 7.
  always_comb begin
    mask_new = '0;
    for (int j = 0; j < 8; j++) mask_new[j] = |adc_info[64 + 2*j +: 2];
  end

`ifdef SCHED_TIMEOUT_EN
  assign unused_ok = ^{adc_info[95:80], adc_info[63:0]};
`else
  assign unused_ok = ^{adc_info[95:80], adc_info[63:0], (TIMEOUT != 0)};
`endif

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    conf_ok_d   = conf_ok_q;
    link_mask_d = link_mask_q;
    conv_cnt_d  = conv_cnt_q;
    ovr_cnt_d   = ovr_cnt_q;
    err_d       = err_q;
    rate_d      = rate_q;
    rcnt_d      = rcnt_q;
    pre_d       = pre_q;
    restart     = 1'b0;

    if (accept && bad_op) err_d = 2'd3;

    case (state_q)
      IDLE, RUN_WAIT: begin
        if (accept) begin
          case (opcode)
            OP_CONF: begin
              err_d       = 2'd0;
              run_d       = 1'b0;
              conf_ok_d   = 1'b0;
              link_mask_d = '0;
              state_d     = CONF_REQ;
            end
            OP_START: if (state_q == IDLE) begin
              if (!conf_ok_q) err_d = 2'd1;
              else begin
                run_d   = 1'b1;
                rate_d  = com_cmd[11:0];
                restart = 1'b1;
                state_d = RUN_WAIT;
              end
            end
            OP_STOP: if (state_q == RUN_WAIT) begin
              run_d   = 1'b0;
              state_d = IDLE;
            end
            OP_SINGLE: if (state_q == IDLE) begin
              if (!conf_ok_q) err_d = 2'd1;
              else            state_d = CONV_REQ;
            end
            default: ;
          endcase
        end
        // An accepted STOP or CONF has already moved the state, so a coincident tick is discarded.
        if (state_q == RUN_WAIT && state_d == RUN_WAIT && tick) state_d = CONV_REQ;
      end
      CONF_REQ: if (fd_adc_conf) state_d = CONF_REL;
      CONF_REL: if (!fd_adc_conf) begin
        link_mask_d = mask_new;
        conf_ok_d   = |mask_new;
        state_d     = IDLE;
      end
      CONV_REQ: begin
        if (tick) ovr_cnt_d = sat_inc8(ovr_cnt_q);
        if (fd_adc_conv) state_d = CONV_REL;
      end
      CONV_REL: begin
        if (tick) ovr_cnt_d = sat_inc8(ovr_cnt_q);
        if (!fd_adc_conv) begin
          conv_cnt_d = conv_cnt_q + CNT_W'(1);
          state_d    = run_q ? RUN_WAIT : IDLE;
        end
      end
`ifdef SCHED_TIMEOUT_EN
      ERR_WAIT: if (!fd_adc_conf && !fd_adc_conv) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

`ifdef SCHED_TIMEOUT_EN
    wdog_d = '0;
    if (state_q inside {CONF_REQ, CONF_REL, CONV_REQ, CONV_REL}) begin
      if (wdog_q == TW'(TIMEOUT - 1)) begin
        state_d = ERR_WAIT;
        err_d   = 2'd2;
        run_d   = 1'b0;
        if (state_q inside {CONF_REQ, CONF_REL}) conf_ok_d = 1'b0;
      end else if (state_d == state_q) begin
        wdog_d = wdog_q + TW'(1);
      end
    end
`endif

    if (restart || !run_d) begin
      pre_d  = '0;
      rcnt_d = '0;
    end else if (pre_wrap) begin
      pre_d  = '0;
      rcnt_d = (rcnt_q == rate_q) ? 12'd0 : rcnt_q + 12'd1;
    end else begin
      pre_d  = pre_q + PW'(1);
    end

    com_ready_d = (state_d == IDLE) || (state_d == RUN_WAIT);
    fs_conf_d   = (state_d == CONF_REQ);
    fs_conv_d   = (state_d == CONV_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      run_q       <= 1'b0;
      conf_ok_q   <= 1'b0;
      link_mask_q <= '0;
      conv_cnt_q  <= '0;
      ovr_cnt_q   <= '0;
      err_q       <= '0;
      rate_q      <= '0;
      rcnt_q      <= '0;
      pre_q       <= '0;
      com_ready_q <= 1'b0;
      fs_conf_q   <= 1'b0;
      fs_conv_q   <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      wdog_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      conf_ok_q   <= conf_ok_d;
      link_mask_q <= link_mask_d;
      conv_cnt_q  <= conv_cnt_d;
      ovr_cnt_q   <= ovr_cnt_d;
      err_q       <= err_d;
      rate_q      <= rate_d;
      rcnt_q      <= rcnt_d;
      pre_q       <= pre_d;
      com_ready_q <= com_ready_d;
      fs_conf_q   <= fs_conf_d;
      fs_conv_q   <= fs_conv_d;
`ifdef SCHED_TIMEOUT_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

  assign com_ready   = com_ready_q;
  assign fs_adc_conf = fs_conf_q;
  assign fs_adc_conv = fs_conv_q;
  assign run         = run_q;
  assign conf_ok     = conf_ok_q;
  assign link_mask   = link_mask_q;
  assign conv_cnt    = conv_cnt_q;
  assign ovr_cnt     = ovr_cnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_console_adc_sched.sv
// Scoreboard bench for console_adc_sched: an fd responder answers each fs, expected fs rise cycles are queued.
module tb_console_adc_sched;
  localparam int unsigned PRESCALE = 4;
  localparam int unsigned TIMEOUT  = 20;
  localparam int unsigned CNT_W    = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             com_valid = 1'b0;
  logic [15:0]      com_cmd = '0;
  logic             com_ready;
  logic             fs_adc_conf;
  logic             fd_adc_conf = 1'b0;
  logic             fs_adc_conv;
  logic             fd_adc_conv = 1'b0;
  logic [95:0]      adc_info = {16'h1234, 16'h4001, 64'hDEAD_BEEF_0BAD_F00D};
  logic             run;
  logic             conf_ok;
  logic [7:0]       link_mask;
  logic [CNT_W-1:0] conv_cnt;
  logic [7:0]       ovr_cnt;
  logic [1:0]       err;

  console_adc_sched #(.PRESCALE(PRESCALE), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .com_valid(com_valid), .com_cmd(com_cmd), .com_ready(com_ready),
    .fs_adc_conf(fs_adc_conf), .fd_adc_conf(fd_adc_conf),
    .fs_adc_conv(fs_adc_conv), .fd_adc_conv(fd_adc_conv),
    .adc_info(adc_info), .run(run), .conf_ok(conf_ok), .link_mask(link_mask),
    .conv_cnt(conv_cnt), .ovr_cnt(ovr_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int conf_dly = 2;
  int conv_dly = 2;
  int conf_wait = 0;
  int conv_wait = 0;
  int rises = 0;
  int exp_conv = 0;
  int exp_rise_q[$];
  int e_rise;
  logic fs_conv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // fd responder: raise fd a programmable number of cycles after fs, drop it once fs falls.
  always @(negedge clk) begin
    if (rst) begin
      fd_adc_conf = 1'b0; fd_adc_conv = 1'b0; conf_wait = 0; conv_wait = 0;
    end else begin
      if (fs_adc_conf && !fd_adc_conf) begin
        conf_wait++;
        if (conf_wait >= conf_dly) begin fd_adc_conf = 1'b1; conf_wait = 0; end
      end else if (!fs_adc_conf) begin
        fd_adc_conf = 1'b0; conf_wait = 0;
      end
      if (fs_adc_conv && !fd_adc_conv) begin
        conv_wait++;
        if (conv_wait >= conv_dly) begin fd_adc_conv = 1'b1; conv_wait = 0; end
      end else if (!fs_adc_conv) begin
        fd_adc_conv = 1'b0; conv_wait = 0;
      end
    end
  end

  // Conversion-request monitor: fd must be low at every fs rise; queued rise cycles are checked in order.
  always @(negedge clk) begin
    if (fs_adc_conv && !fs_conv_prev) begin
      rises++;
      total++;
      if (fd_adc_conv !== 1'b0) begin
        bad++; $display("FAIL conv_rise_fd_low: fd_adc_conv=%b want 0 at cycle %0d", fd_adc_conv, cyc);
      end
      if (exp_rise_q.size() > 0) begin
        e_rise = exp_rise_q.pop_front();
        total++;
        if (cyc !== e_rise) begin
          bad++; $display("FAIL conv_rise_time: got cycle %0d want %0d", cyc, e_rise);
        end
      end
    end
    fs_conv_prev = fs_adc_conv;
  end

  task automatic send(input logic [3:0] op, input logic [11:0] rate, output int acc);
    int n = 0;
    acc = -1;
    while (com_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (com_ready !== 1'b1) begin
      total++; bad++; $display("FAIL cmd_ready_wait: com_ready=%b want 1 op=%0h", com_ready, op);
    end else begin
      com_valid = 1'b1; com_cmd = {op, rate};
      @(posedge clk);
      @(negedge clk);
      com_valid = 1'b0; com_cmd = '0;
      acc = cyc;
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (com_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (com_ready !== 1'b1) begin
      total++; bad++; $display("FAIL %s_ready_timeout: com_ready=%b want 1", tag, com_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (com_ready !== 1'b0) begin bad++; $display("FAIL reset_com_ready: got %b want 0", com_ready); end
    total++; if ({fs_adc_conf, fs_adc_conv, run, conf_ok} !== 4'b0) begin bad++; $display("FAIL reset_flags: got %b want 0000", {fs_adc_conf, fs_adc_conv, run, conf_ok}); end
    total++; if (link_mask !== 8'h00) begin bad++; $display("FAIL reset_link_mask: got %h want 00", link_mask); end
    total++; if (conv_cnt !== '0 || ovr_cnt !== 8'h00) begin bad++; $display("FAIL reset_counts: conv=%0d ovr=%0d want 0 0", conv_cnt, ovr_cnt); end
    total++; if (err !== 2'd0) begin bad++; $display("FAIL reset_err: got %0d want 0", err); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (com_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", com_ready); end
  endtask

  task automatic test_single_unconf();
    int acc;
    send(4'd4, 12'd0, acc);
    repeat (10) @(negedge clk);
    total++; if (err !== 2'd1) begin bad++; $display("FAIL unconf_err: got %0d want 1", err); end
    total++; if (rises !== 0 || fs_adc_conv !== 1'b0) begin bad++; $display("FAIL unconf_no_conv: rises=%0d fs=%b want 0 0", rises, fs_adc_conv); end
    total++; if (com_ready !== 1'b1) begin bad++; $display("FAIL unconf_idle: com_ready=%b want 1", com_ready); end
  endtask

  task automatic test_conf();
    int acc;
    conf_dly = 2;
    send(4'd1, 12'd0, acc);
    total++; if (fs_adc_conf !== 1'b1) begin bad++; $display("FAIL conf_fs_rise: got %b want 1", fs_adc_conf); end
    total++; if (err !== 2'd0) begin bad++; $display("FAIL conf_err_clear: got %0d want 0", err); end
    total++; if (com_ready !== 1'b0) begin bad++; $display("FAIL conf_busy: com_ready=%b want 0", com_ready); end
    wait_ready("conf");
    total++; if (link_mask !== 8'h81) begin bad++; $display("FAIL conf_link_mask: got %h want 81", link_mask); end
    total++; if (conf_ok !== 1'b1) begin bad++; $display("FAIL conf_ok: got %b want 1", conf_ok); end
    total++; if (fs_adc_conf !== 1'b0) begin bad++; $display("FAIL conf_fs_drop: got %b want 0", fs_adc_conf); end
  endtask

  task automatic test_single();
    int acc;
    int base = rises;
    send(4'd4, 12'd0, acc);
    exp_conv++;
    total++; if (fs_adc_conv !== 1'b1) begin bad++; $display("FAIL single_fs_rise: got %b want 1", fs_adc_conv); end
    wait_ready("single");
    repeat (2) @(negedge clk);
    total++; if (conv_cnt !== CNT_W'(exp_conv)) begin bad++; $display("FAIL single_conv_cnt: got %0d want %0d", conv_cnt, exp_conv); end
    total++; if (run !== 1'b0 || rises - base !== 1) begin bad++; $display("FAIL single_one_shot: run=%b rises=%0d want 0 1", run, rises - base); end
  endtask

  task automatic test_bad_opcode();
    int acc;
    send(4'hF, 12'h0AB, acc);
    repeat (2) @(negedge clk);
    total++; if (err !== 2'd3) begin bad++; $display("FAIL badop_err: got %0d want 3", err); end
    total++; if (com_ready !== 1'b1 || run !== 1'b0 || fs_adc_conv !== 1'b0) begin bad++; $display("FAIL badop_state: ready=%b run=%b fs=%b want 1 0 0", com_ready, run, fs_adc_conv); end
    total++; if (conf_ok !== 1'b1 || link_mask !== 8'h81) begin bad++; $display("FAIL badop_conf_kept: conf_ok=%b mask=%h want 1 81", conf_ok, link_mask); end
  endtask

  task automatic test_periodic();
    int acc;
    int n = 0;
    int base = rises;
    conv_dly = 2;
    send(4'd2, 12'd3, acc);
    for (int k = 1; k <= 5; k++) exp_rise_q.push_back(acc + 16 * k);
    total++; if (run !== 1'b1) begin bad++; $display("FAIL periodic_run: got %b want 1", run); end
    while (rises - base < 5 && n < 300) begin @(negedge clk); n++; end
    total++; if (rises - base !== 5) begin bad++; $display("FAIL periodic_rises: got %0d want 5", rises - base); end
    repeat (5) @(negedge clk);
    exp_conv += 5;
    total++; if (conv_cnt !== CNT_W'(exp_conv)) begin bad++; $display("FAIL periodic_conv_cnt: got %0d want %0d", conv_cnt, exp_conv); end
    total++; if (ovr_cnt !== 8'd0) begin bad++; $display("FAIL periodic_ovr: got %0d want 0", ovr_cnt); end
    send(4'd3, 12'd0, acc);
    total++; if (run !== 1'b0) begin bad++; $display("FAIL stop_run: got %b want 0", run); end
    repeat (40) @(negedge clk);
    total++; if (rises - base !== 5 || fs_adc_conv !== 1'b0) begin bad++; $display("FAIL stop_no_conv: rises=%0d fs=%b want 5 0", rises - base, fs_adc_conv); end
    total++; if (exp_rise_q.size() !== 0) begin bad++; $display("FAIL periodic_queue: left=%0d want 0", exp_rise_q.size()); end
  endtask

  // rate 0 gives a tick every 4 clocks; a 10-cycle fd delay makes each conversion last 12 clocks,
  // so two ticks fall inside every conversion and are dropped.
  task automatic test_overrun();
    int acc;
    int n = 0;
    int base = rises;
    conv_dly = 10;
    send(4'd2, 12'd0, acc);
    exp_rise_q.push_back(acc + 4);
    exp_rise_q.push_back(acc + 16);
    exp_rise_q.push_back(acc + 28);
    while (rises - base < 3 && n < 200) begin @(negedge clk); n++; end
    send(4'd3, 12'd0, acc);
    exp_conv += 3;
    repeat (30) @(negedge clk);
    total++; if (ovr_cnt !== 8'd6) begin bad++; $display("FAIL overrun_cnt: got %0d want 6", ovr_cnt); end
    total++; if (conv_cnt !== CNT_W'(exp_conv)) begin bad++; $display("FAIL overrun_conv_cnt: got %0d want %0d", conv_cnt, exp_conv); end
    total++; if (rises - base !== 3 || run !== 1'b0) begin bad++; $display("FAIL overrun_stop: rises=%0d run=%b want 3 0", rises - base, run); end
    conv_dly = 2;
  endtask

`ifdef SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int acc;
    int n = 0;
    int r;
    conv_dly = 1000;
    send(4'd2, 12'd0, acc);
    while (fs_adc_conv !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    r = cyc;
    n = 0;
    while (fs_adc_conv !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    total++; if (cyc - r !== 20) begin bad++; $display("FAIL timeout_fs_len: got %0d want 20", cyc - r); end
    total++; if (err !== 2'd2 || run !== 1'b0) begin bad++; $display("FAIL timeout_err_run: err=%0d run=%b want 2 0", err, run); end
    repeat (3) @(negedge clk);
    total++; if (com_ready !== 1'b1 || conf_ok !== 1'b1) begin bad++; $display("FAIL timeout_idle: ready=%b conf_ok=%b want 1 1", com_ready, conf_ok); end
    conv_dly = 2;
  endtask
`endif

  initial begin
    test_reset();
    test_single_unconf();
    test_conf();
    test_single();
    test_bad_opcode();
    test_periodic();
    test_overrun();
`ifdef SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
